// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//   Handshake and operand bundle between the core's decode/execute datapath
//   and the multi-cycle RV32M multiply/divide sequencer.
//   start    : core -> seq, current instruction is an M-extension op
//   func3    : core -> seq, operation select (MUL..REMU)
//   rs1_data : core -> seq, operand A (multiplicand / dividend)
//   rs2_data : core -> seq, operand B (multiplier / divisor)
//   stall    : seq -> core, freeze PC and inhibit register writeback
//   done     : seq -> core, result valid this cycle (one-cycle pulse)
//   result   : seq -> core, registered result
interface muldiv_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, func3, rs1_data, rs2_data,
        input  stall, done, result
    );

    modport slave (
        input  start, func3, rs1_data, rs2_data,
        output stall, done, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle sequencer for RV32M multiply/divide. Accepts one operation
//   while idle, stalls the core, runs XLEN shift-add (multiply) or restoring
//   (divide) steps on operand magnitudes, applies signs, and presents a
//   registered result with a one-cycle done pulse.
//   clk   : core clock, rising-edge
//   reset : asynchronous, active-high; returns to idle and clears result
//   bus   : muldiv_sequencer_if slave modport (start/func3/operands in,
//           stall/done/result out)
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input logic             clk,
    input logic             reset,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      func3_q, func3_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    // hi holds the upper product half (multiply) or the partial remainder
    // (divide); lo holds the multiplier (multiply) or the dividend shifting
    // out while quotient bits shift in (divide).
    logic [XLEN:0]   hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Accept-time decode of the incoming operation.
    logic            in_div, in_a_signed, in_b_signed, in_a_neg, in_b_neg;
    logic [XLEN-1:0] in_a_mag, in_b_mag, special_res;
    logic            div_zero, div_ovf;

    // Iteration datapath.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN+1:0] div_diff;
    logic            div_ok;

    // Sign fix-up datapath.
    logic [2*XLEN-1:0] prod_mag, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;

    always_comb begin
        in_div      = bus.func3[2];
        in_a_signed = (bus.func3 == 3'b001) || (bus.func3 == 3'b010) ||
                      (bus.func3 == 3'b100) || (bus.func3 == 3'b110);
        in_b_signed = (bus.func3 == 3'b001) || (bus.func3 == 3'b100) ||
                      (bus.func3 == 3'b110);
        in_a_neg    = in_a_signed && bus.rs1_data[XLEN-1];
        in_b_neg    = in_b_signed && bus.rs2_data[XLEN-1];
        in_a_mag    = in_a_neg ? -bus.rs1_data : bus.rs1_data;
        in_b_mag    = in_b_neg ? -bus.rs2_data : bus.rs2_data;
        div_zero    = in_div && (bus.rs2_data == '0);
        // Signed overflow only for DIV/REM (func3[0]==0).
        div_ovf     = in_div && !bus.func3[0] &&
                      (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (bus.rs2_data == '1);
        if (div_zero) begin
            special_res = bus.func3[1] ? bus.rs1_data : '1;
        end else begin
            special_res = bus.func3[1] ? '0 : bus.rs1_data;
        end
    end

    always_comb begin
        // Shift-add: add multiplicand into the upper half when the current
        // multiplier LSB is set, then shift the whole {hi,lo} right by one.
        mul_sum   = {1'b0, hi_q[XLEN-1:0]} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        // Restoring divide: bring in the next dividend bit, trial-subtract.
        div_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
        div_ok    = !div_diff[XLEN+1];
    end

    always_comb begin
        prod_mag = {hi_q[XLEN-1:0], lo_q};
        prod_s   = (sign_a_q ^ sign_b_q) ? -prod_mag : prod_mag;
        quo_s    = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
        rem_s    = sign_a_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];
        case (func3_q)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_s;
            default:                fix_res = rem_s;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        func3_d  = func3_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    func3_d  = bus.func3;
                    sign_a_d = in_a_neg;
                    sign_b_d = in_b_neg;
                    cnt_d    = '0;
                    hi_d     = '0;
                    if (in_div) begin
                        lo_d   = in_a_mag;
                        opnd_d = in_b_mag;
                    end else begin
                        lo_d   = in_b_mag;
                        opnd_d = in_a_mag;
                    end
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (func3_q[2]) begin
                    hi_d = div_ok ? div_diff[XLEN:0] : div_shift;
                    lo_d = {lo_q[XLEN-2:0], div_ok};
                end else begin
                    hi_d = {1'b0, mul_sum[XLEN:1]};
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = fix_res;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            func3_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            func3_q  <= func3_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.stall  = ((state_q == IDLE) && bus.start) ||
                        (state_q == CALC) || (state_q == FIX);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed, table-driven bench for muldiv_sequencer: per-vector result,
//   done cycle and stall-cycle count, plus hand-written reset and
//   back-to-back sequences.
module tb_muldiv_sequencer;
    logic clk;
    logic reset;

    muldiv_sequencer_if #(.XLEN(32)) bus ();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int unsigned dc;   // expected done cycle relative to accept
        bit          scr;  // scramble operands/func3 after accept
        bit          drop; // drop start during CALC
    } vec_t;

    vec_t vt[$];
    int unsigned nvec = 0;
    int unsigned nerr = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered just after a rising edge; that cycle is the accept cycle 0.
    // Returns after sampling the done cycle, with start still asserted.
    task automatic run_op(input string nm, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int unsigned exp_dc,
                          input bit scr, input bit drop,
                          output int unsigned got_dc);
        int unsigned stalls;
        bit seen;
        stalls = 0;
        seen   = 1'b0;
        got_dc = 0;
        bus.start    = 1'b1;
        bus.func3    = f3;
        bus.rs1_data = a;
        bus.rs2_data = b;
        for (int unsigned c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.done) begin
                check({nm, " done_cycle"}, c, exp_dc);
                check({nm, " stall_in_done"}, {31'd0, bus.stall}, 32'd0);
                check({nm, " stall_cycles"}, stalls, exp_dc);
                check({nm, " result"}, bus.result, exp);
                got_dc = c;
                seen   = 1'b1;
                break;
            end
            if (bus.stall) stalls++;
            @(posedge clk);
            #1;
            if (c == 0 && scr) begin
                bus.func3    = ~f3;
                bus.rs1_data = a ^ 32'h5A5A_F00F;
                bus.rs2_data = b + 32'd3;
            end
            if (c == 1 && drop) bus.start = 1'b0;
        end
        if (!seen) begin
            nvec++;
            nerr++;
            $display("FAIL %s timeout: no done within 100 cycles", nm);
        end
        bus.start = 1'b1;
    endtask

    task automatic idle_after(input string nm);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check({nm, " done_one_cycle"}, {31'd0, bus.done}, 32'd0);
        check({nm, " stall_idle"}, {31'd0, bus.stall}, 32'd0);
    endtask

    initial begin
        int unsigned d1, d2;

        vt.push_back('{"MUL",        3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, 0});
        vt.push_back('{"MULH",       3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, 0});
        vt.push_back('{"MULHSU",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0, 0});
        vt.push_back('{"MULHU",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0, 0});
        vt.push_back('{"DIV",        3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34, 0, 0});
        vt.push_back('{"REM",        3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34, 0, 0});
        vt.push_back('{"DIVU",       3'b101, 32'd100,      32'd7,        32'd14,        34, 0, 0});
        vt.push_back('{"REMU",       3'b111, 32'd100,      32'd7,        32'd2,         34, 0, 0});
        vt.push_back('{"DIVU_z",     3'b101, 32'h1234,     32'd0,        32'hFFFF_FFFF, 1,  0, 0});
        vt.push_back('{"REM_z",      3'b110, 32'h1234,     32'd0,        32'h0000_1234, 1,  0, 0});
        vt.push_back('{"DIV_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0});
        vt.push_back('{"REM_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0});
        vt.push_back('{"DIV_z",      3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 1,  0, 0});
        vt.push_back('{"REMU_z",     3'b111, 32'd9,        32'd0,        32'd9,         1,  0, 0});
        vt.push_back('{"DIVU_ovfpat",3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        34, 0, 0});
        vt.push_back('{"MUL_scr",    3'b000, 32'h1234_5678, 32'h10,       32'h2345_6780, 34, 1, 0});
        vt.push_back('{"MULH_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0, 0});
        vt.push_back('{"MULHU_sh",   3'b011, 32'h8000_0000, 32'd2,        32'd1,         34, 0, 1});
        vt.push_back('{"DIV_negb",   3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0, 0});
        vt.push_back('{"REM_negb",   3'b110, 32'd7,        32'hFFFF_FFFE, 32'd1,         34, 1, 1});
        vt.push_back('{"DIV_min",    3'b100, 32'h8000_0000, 32'd2,        32'hC000_0000, 34, 0, 0});
        vt.push_back('{"REM_min3",   3'b110, 32'h8000_0000, 32'd3,        32'hFFFF_FFFE, 34, 0, 0});
        vt.push_back('{"DIVU_max",   3'b101, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 34, 0, 0});
        vt.push_back('{"REMU_16",    3'b111, 32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 34, 0, 0});

        // Reset state, including stall following start combinationally.
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.func3    = 3'b000;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst done", {31'd0, bus.done}, 32'd0);
        check("rst result", bus.result, 32'd0);
        check("rst stall_nostart", {31'd0, bus.stall}, 32'd0);
        bus.start = 1'b1;
        #1;
        check("rst stall_start", {31'd0, bus.stall}, 32'd1);
        bus.start = 1'b0;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vt[i]) begin
            run_op(vt[i].nm, vt[i].f3, vt[i].a, vt[i].b, vt[i].exp, vt[i].dc,
                   vt[i].scr, vt[i].drop, d1);
            idle_after(vt[i].nm);
            @(posedge clk);
            #1;
        end

        // Reset in cycle 10 of a MUL; previous result (0xF) is nonzero.
        bus.start    = 1'b1;
        bus.func3    = 3'b000;
        bus.rs1_data = 32'd6;
        bus.rs2_data = 32'd9;
        repeat (10) @(posedge clk);
        #1;
        check("midrst stall_before", {31'd0, bus.stall}, 32'd1);
        reset = 1'b1;
        #1;
        check("midrst done", {31'd0, bus.done}, 32'd0);
        check("midrst result", bus.result, 32'd0);
        bus.start = 1'b0;
        #1;
        check("midrst stall_nostart", {31'd0, bus.stall}, 32'd0);
        bus.start = 1'b1;
        #1;
        check("midrst stall_start", {31'd0, bus.stall}, 32'd1);
        bus.start = 1'b0;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_op("MUL_reissue", 3'b000, 32'd6, 32'd9, 32'd54, 34, 1'b0, 1'b0, d1);
        idle_after("MUL_reissue");
        @(posedge clk);
        #1;

        // Back-to-back: MUL then REMU with start held through DONE.
        run_op("B2B_MUL", 3'b000, 32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, 34, 1'b0, 1'b0, d1);
        @(posedge clk);
        #1;
        run_op("B2B_REMU", 3'b111, 32'd1000, 32'd33, 32'd10, 34, 1'b0, 1'b0, d2);
        check("B2B second_done_abs", 35 + d2, 32'd69);
        idle_after("B2B_REMU");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
